// File: rtl/inv_share_arb_pkg.sv
// Shared state encodings and counter sizing for the inverter-bank arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package inv_share_arb_pkg;

  // Width of the settle down-counter; covers settle times 1..15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/inv_share_arb_rr_arb2.sv
// Two-way round-robin grant: favours the requester that was not served last.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the grant.
module rr_arb2
  import inv_share_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic vld_o,
  output logic gnt_o
);

  // A lone requester always wins; a tie goes to whoever was not served last.
  always_comb begin
    vld_o = req0_i | req1_i;
    if (req0_i && req1_i) begin
      gnt_o = ~last_i;
    end else begin
      gnt_o = req1_i;
    end
  end

endmodule

// File: rtl/inv_share_arb.sv
// Shares one external inverter bank between two REQ/ACK requesters and self-checks it.
// Latency: ACK and Y appear SETTLE edges after the grant edge; one IDLE cycle between jobs.
// Backpressure: ACK is held until the served requester drops REQ; the other requester waits in IDLE.
module inv_share_arb
  import inv_share_arb_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic [WIDTH-1:0] D0,
  output logic             ACK0,
  output logic [WIDTH-1:0] Y0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] D1,
  output logic             ACK1,
  output logic [WIDTH-1:0] Y1,
  output logic [WIDTH-1:0] INV_A,
  input  logic [WIDTH-1:0] INV_Y,
  output logic             BUSY,
  output logic             ERR
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               last_q;
  logic               gnt_q;
  logic [WIDTH-1:0]   inv_a_q;
  logic [WIDTH-1:0]   y0_q;
  logic [WIDTH-1:0]   y1_q;
  logic               ack0_q;
  logic               ack1_q;
  logic               err_q;

  logic               arb_vld;
  logic               arb_gnt;
  logic               req_g;
  logic               inv_bad;

  rr_arb2 u_arb (
    .req0_i (REQ0),
    .req1_i (REQ1),
    .last_i (last_q),
    .vld_o  (arb_vld),
    .gnt_o  (arb_gnt)
  );

  // Helper terms: counter decrement, the granted requester's REQ, and the bank self-check.
  always_comb begin
    cnt_d   = cnt_q - CNT_W'(1);
    req_g   = gnt_q ? REQ1 : REQ0;
    inv_bad = (INV_Y != ~inv_a_q);
  end

  // Transaction FSM with all outputs registered; reset aborts any job in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      inv_a_q <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_vld) begin
            gnt_q   <= arb_gnt;
            inv_a_q <= arb_gnt ? D1 : D0;
            cnt_q   <= CNT_LOAD;
            state_q <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_d;
          end else begin
            if (gnt_q) begin
              y1_q   <= INV_Y;
              ack1_q <= 1'b1;
            end else begin
              y0_q   <= INV_Y;
              ack0_q <= 1'b1;
            end
            if (inv_bad) begin
              err_q <= 1'b1;
            end
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!req_g) begin
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            last_q  <= gnt_q;
            inv_a_q <= '0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Drive ports straight from the registers.
  always_comb begin
    ACK0  = ack0_q;
    ACK1  = ack1_q;
    Y0    = y0_q;
    Y1    = y1_q;
    INV_A = inv_a_q;
    BUSY  = (state_q != ST_IDLE);
    ERR   = err_q;
  end

endmodule

// File: tb/tb_inv_share_arb.sv
// Randomized and directed bench for inv_share_arb against a transaction-timeline model.
// Latency: checks every cycle on the falling edge.
// Backpressure: requesters hold REQ until ACK, with occasional early drops.
module tb_inv_share_arb;

  localparam int W      = 4;
  localparam int SETTLE = 2;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         REQ0 = 1'b0, REQ1 = 1'b0;
  logic [W-1:0] D0 = '0, D1 = '0;
  logic         ACK0, ACK1, BUSY, ERR;
  logic [W-1:0] Y0, Y1, INV_A, INV_Y;
  logic         fault = 1'b0;

  // Stand-in for the 74x04 bank, with a stuck-at-zero fault option.
  assign INV_Y = fault ? '0 : ~INV_A;

  inv_share_arb #(.WIDTH(W), .SETTLE(SETTLE)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .D0(D0), .ACK0(ACK0), .Y0(Y0),
    .REQ1(REQ1), .D1(D1), .ACK1(ACK1), .Y1(Y1),
    .INV_A(INV_A), .INV_Y(INV_Y), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Model: a transaction in flight, its owner and operand, and edges elapsed since its grant.
  bit         m_in;
  bit         m_g;
  bit [W-1:0] m_op;
  int         m_k;
  bit         m_last;
  bit [W-1:0] m_y [2];
  bit         m_ack [2];
  bit         m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in = 0; m_g = 0; m_op = '0; m_k = 0; m_last = 1;
    m_y[0] = '0; m_y[1] = '0; m_ack[0] = 0; m_ack[1] = 0; m_err = 0;
  endtask

  // Advance the model across one rising edge given the inputs present before it.
  task automatic model_edge(input bit r0, input bit [W-1:0] d0, input bit r1,
                            input bit [W-1:0] d1, input bit flt);
    bit [W-1:0] invy;
    bit         g;
    invy = flt ? '0 : ~(m_in ? m_op : '0);
    if (!m_in) begin
      if (r0 || r1) begin
        g    = (r0 && r1) ? !m_last : r1;
        m_in = 1; m_g = g; m_op = g ? d1 : d0; m_k = 0;
      end
    end else begin
      m_k++;
      if (m_k == SETTLE) begin
        m_y[m_g]   = invy;
        m_ack[m_g] = 1;
        if (invy != ~m_op) m_err = 1;
      end else if (m_k > SETTLE) begin
        if (!(m_g ? r1 : r0)) begin
          m_ack[m_g] = 0;
          m_last     = m_g;
          m_in       = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("ack0",  ACK0, m_ack[0]);
    chk("ack1",  ACK1, m_ack[1]);
    chk("y0",    Y0, m_y[0]);
    chk("y1",    Y1, m_y[1]);
    chk("inv_a", INV_A, m_in ? m_op : '0);
    chk("busy",  BUSY, m_in);
    chk("err",   ERR, m_err);
    chk("ack_excl", ACK0 & ACK1, 1'b0);
  endtask

  // One cycle: check outputs on the falling edge, then drive inputs for the next rising edge.
  task automatic cyc(input bit r0, input bit [W-1:0] d0, input bit r1,
                     input bit [W-1:0] d1, input bit flt);
    @(negedge CLK);
    compare_all();
    REQ0 = r0; D0 = d0; REQ1 = r1; D1 = d1; fault = flt;
    model_edge(r0, d0, r1, d1, flt);
  endtask

  // Mid-cycle reset pulse: outputs must clear before any clock edge.
  task automatic pulse_reset();
    @(negedge CLK);
    compare_all();
    #2 RST = 1'b1;
    #1;
    chk("rst_ack0", ACK0, 1'b0);
    chk("rst_ack1", ACK1, 1'b0);
    chk("rst_y0", Y0, 4'b0000);
    chk("rst_y1", Y1, 4'b0000);
    chk("rst_inv_a", INV_A, 4'b0000);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_err", ERR, 1'b0);
    model_reset();
    REQ0 = 0; REQ1 = 0; D0 = '0; D1 = '0; fault = 0;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic after_edge();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    bit         r0, r1, flt;
    bit [W-1:0] d0, d1;
    model_reset();
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // Single request: operand, latency and release.
    pulse_reset();
    cyc(1, 4'b1010, 0, 0, 0); after_edge();
    chk("t2_inv_a", INV_A, 4'b1010);
    chk("t2_busy", BUSY, 1'b1);
    cyc(1, 4'b1010, 0, 0, 0);
    cyc(1, 4'b1010, 0, 0, 0); after_edge();
    chk("t2_ack0", ACK0, 1'b1);
    chk("t2_y0", Y0, 4'b0101);
    cyc(0, 4'b1010, 0, 0, 0); after_edge();
    chk("t2_ack0_drop", ACK0, 1'b0);
    chk("t2_busy_drop", BUSY, 1'b0);
    chk("t2_err", ERR, 1'b0);

    // Tie after reset goes to requester 0; then requester 1 wins the next tie.
    pulse_reset();
    cyc(1, 4'b1111, 1, 4'b0000, 0);
    cyc(1, 4'b1111, 1, 4'b0000, 0);
    cyc(1, 4'b1111, 1, 4'b0000, 0); after_edge();
    chk("t3_y0", Y0, 4'b0000);
    chk("t3_ack0", ACK0, 1'b1);
    cyc(0, 4'b1111, 1, 4'b0000, 0); after_edge();
    chk("t3_gap_busy", BUSY, 1'b0);
    cyc(1, 4'b0101, 1, 4'b0000, 0); after_edge();
    chk("t3_tie_inv_a", INV_A, 4'b0000);
    cyc(1, 4'b0101, 1, 4'b0000, 0);
    cyc(1, 4'b0101, 1, 4'b0000, 0); after_edge();
    chk("t3_y1", Y1, 4'b1111);
    chk("t3_ack1", ACK1, 1'b1);
    chk("t3_ack0_idle", ACK0, 1'b0);
    cyc(1, 4'b0101, 0, 4'b0000, 0);
    cyc(1, 4'b0101, 0, 4'b0000, 0);
    cyc(1, 4'b0101, 0, 4'b0000, 0);
    cyc(1, 4'b0101, 0, 4'b0000, 0); after_edge();
    chk("t3_y0_second", Y0, 4'b1010);
    cyc(0, 4'b0101, 0, 4'b0000, 0);

    // Stuck inverter sets sticky ERR, which survives a good job.
    cyc(0, 0, 1, 4'b0011, 1);
    cyc(0, 0, 1, 4'b0011, 1);
    cyc(0, 0, 1, 4'b0011, 1); after_edge();
    chk("t4_y1", Y1, 4'b0000);
    chk("t4_ack1", ACK1, 1'b1);
    chk("t4_err", ERR, 1'b1);
    cyc(0, 0, 0, 4'b0011, 0);
    cyc(0, 0, 1, 4'b0011, 0);
    cyc(0, 0, 1, 4'b0011, 0);
    cyc(0, 0, 1, 4'b0011, 0); after_edge();
    chk("t4_y1_good", Y1, 4'b1100);
    chk("t4_err_sticky", ERR, 1'b1);
    cyc(0, 0, 0, 4'b0011, 0);

    // Reset during DRIVE aborts; retry completes.
    pulse_reset();
    cyc(1, 4'b0110, 0, 0, 0); after_edge();
    chk("t5_busy", BUSY, 1'b1);
    pulse_reset();
    chk("t5_y0_abort", Y0, 4'b0000);
    cyc(1, 4'b0110, 0, 0, 0);
    cyc(1, 4'b0110, 0, 0, 0);
    cyc(1, 4'b0110, 0, 0, 0); after_edge();
    chk("t5_y0", Y0, 4'b1001);
    cyc(0, 4'b0110, 0, 0, 0);

    // Early REQ drop and operand change during DRIVE.
    cyc(1, 4'b1100, 0, 0, 0);
    cyc(0, 4'b0000, 0, 0, 0);
    cyc(0, 4'b0000, 0, 0, 0); after_edge();
    chk("t6_ack0", ACK0, 1'b1);
    chk("t6_y0", Y0, 4'b0011);
    cyc(0, 4'b0000, 0, 0, 0); after_edge();
    chk("t6_ack0_pulse", ACK0, 1'b0);

    // Randomized traffic.
    r0 = 0; r1 = 0; d0 = '0; d1 = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        pulse_reset();
        r0 = 0; r1 = 0;
      end
      if (!r0) begin
        if ($urandom_range(0, 2) == 0) begin r0 = 1; d0 = W'($urandom); end
      end else if (m_ack[0]) begin
        if ($urandom_range(0, 3) != 0) r0 = 0;
      end else if (m_in && !m_g) begin
        if ($urandom_range(0, 19) == 0) r0 = 0;
        if ($urandom_range(0, 3) == 0) d0 = W'($urandom);
      end
      if (!r1) begin
        if ($urandom_range(0, 2) == 0) begin r1 = 1; d1 = W'($urandom); end
      end else if (m_ack[1]) begin
        if ($urandom_range(0, 3) != 0) r1 = 0;
      end else if (m_in && m_g) begin
        if ($urandom_range(0, 19) == 0) r1 = 0;
        if ($urandom_range(0, 3) == 0) d1 = W'($urandom);
      end
      flt = ($urandom_range(0, 19) == 0);
      cyc(r0, d0, r1, d1, flt);
    end
    @(negedge CLK);
    compare_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
